// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath.
//   DATA_W            : width of products, bias and activations
//   SAT_MAX / SAT_MIN : 32-bit signed clip limits
//   state_e           : neuron accumulator FSM states
//   cnt_width()       : width of a counter that indexes 0..n-1 (at least 1 bit)
package nn_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        BIAS,
        OUT
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neuron_accumulator_if.sv
// Control, product-stream and activation-stream signals of one neuron accumulator.
//   start/bias                      : neuron request and its bias (master -> slave)
//   prod_valid/prod_data/prod_ready : product stream into the accumulator
//   out_valid/out_data/out_ready    : activation stream to the next layer
//   busy/sat_flag                   : status from the accumulator
// The accumulator uses the slave modport; whatever drives it uses master.
interface neuron_accumulator_if;
    import nn_pkg::*;

    logic              start;
    logic [DATA_W-1:0] bias;
    logic              prod_valid;
    logic [DATA_W-1:0] prod_data;
    logic              prod_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              busy;
    logic              sat_flag;

    modport master (
        output start, bias, prod_valid, prod_data, out_ready,
        input  prod_ready, out_valid, out_data, busy, sat_flag
    );

    modport slave (
        input  start, bias, prod_valid, prod_data, out_ready,
        output prod_ready, out_valid, out_data, busy, sat_flag
    );

endinterface

// File: rtl/sat_relu.sv
// Combinational output stage: clips a wide signed sum to 32 bits and optionally
// applies ReLU.
//   acc    : ACC_W-bit signed sum
//   result : 32-bit activation
//   sat    : sum fell outside the 32-bit signed range
module sat_relu
    import nn_pkg::*;
#(
    parameter int unsigned ACC_W   = 48,
    parameter bit          RELU_EN = 1'b1
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic        [DATA_W-1:0] result,
    output logic                     sat
);

    // Clip limits sign-extended to the accumulator width for signed compares.
    localparam logic signed [ACC_W-1:0] MAX_EXT = {{(ACC_W-DATA_W){1'b0}}, SAT_MAX};
    localparam logic signed [ACC_W-1:0] MIN_EXT = {{(ACC_W-DATA_W){1'b1}}, SAT_MIN};

    always_comb begin
        sat    = 1'b0;
        result = acc[DATA_W-1:0];
        if (acc > MAX_EXT) begin
            sat    = 1'b1;
            result = SAT_MAX;
        end else if (acc < MIN_EXT) begin
            sat    = 1'b1;
            result = SAT_MIN;
        end
        // ReLU acts on the clipped value, so a negative overflow still reports sat.
        if (RELU_EN && result[DATA_W-1]) begin
            result = '0;
        end
    end

endmodule

// File: rtl/neuron_accumulator.sv
// Sequential multiply-accumulate back end for one neuron.
// Sums N_INPUTS signed products, adds the bias captured at start, saturates to
// 32 bits, optionally applies ReLU and holds the activation until accepted.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : neuron_accumulator_if.slave (start/bias, product stream, activation
//           stream, busy, sat_flag)
module neuron_accumulator
    import nn_pkg::*;
#(
    parameter int unsigned N_INPUTS = 784,
    parameter int unsigned ACC_W    = 48,
    parameter bit          RELU_EN  = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    neuron_accumulator_if.slave bus
);

    localparam int unsigned      CNT_W    = cnt_width(N_INPUTS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

    function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    endfunction

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [CNT_W-1:0]  cnt_q, cnt_d;
    logic        [DATA_W-1:0] bias_q, bias_d;
    logic        [DATA_W-1:0] out_data_q, out_data_d;
    logic                     sat_q, sat_d;

    logic                     beat;
    logic signed [ACC_W-1:0]  acc_bias;
    logic        [DATA_W-1:0] sr_result;
    logic                     sr_sat;

    assign beat     = (state_q == ACCUM) && bus.prod_valid;
    assign acc_bias = acc_q + sext(bias_q);

    // Fed from the post-bias sum so the activation is registered on entry to OUT.
    sat_relu #(
        .ACC_W   (ACC_W),
        .RELU_EN (RELU_EN)
    ) u_sat_relu (
        .acc    (acc_bias),
        .result (sr_result),
        .sat    (sr_sat)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = ACCUM;
            ACCUM:   if (beat && (cnt_q == CNT_LAST)) state_d = BIAS;
            BIAS:    state_d = OUT;
            OUT:     if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.prod_ready = (state_q == ACCUM);
        bus.out_valid  = (state_q == OUT);
        bus.busy       = (state_q != IDLE);
    end

    // Datapath next-state
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        bias_d     = bias_q;
        out_data_d = out_data_q;
        sat_d      = sat_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d  = '0;
                    cnt_d  = '0;
                    bias_d = bus.bias;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d = acc_q + sext(bus.prod_data);
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BIAS: begin
                acc_d      = acc_bias;
                out_data_d = sr_result;
                sat_d      = sr_sat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            bias_q     <= '0;
            out_data_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            bias_q     <= bias_d;
            out_data_q <= out_data_d;
            sat_q      <= sat_d;
        end
    end

    assign bus.out_data = out_data_q;
    assign bus.sat_flag = sat_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench for neuron_accumulator. Three instances share stimulus:
//   dut0: N_INPUTS=4,   RELU_EN=1
//   dut1: N_INPUTS=4,   RELU_EN=0
//   dut2: N_INPUTS=784, RELU_EN=1
// Only the selected instance sees start; the others stay idle. Expected results
// are pushed to a queue when a neuron is launched and popped on output handshakes.
module tb_neuron_accumulator;

    typedef struct packed {
        logic [31:0] data;
        logic        sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int          sel;
    logic        start_r;
    logic [31:0] bias_r;
    logic        pv_r;
    logic [31:0] pd_r;
    logic        or_r;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t exp_q[$];
    int   prod_tab[1024];

    neuron_accumulator_if b0 ();
    neuron_accumulator_if b1 ();
    neuron_accumulator_if b2 ();

    assign b0.start = start_r && (sel == 0);
    assign b1.start = start_r && (sel == 1);
    assign b2.start = start_r && (sel == 2);
    assign b0.bias = bias_r;      assign b1.bias = bias_r;      assign b2.bias = bias_r;
    assign b0.prod_valid = pv_r;  assign b1.prod_valid = pv_r;  assign b2.prod_valid = pv_r;
    assign b0.prod_data = pd_r;   assign b1.prod_data = pd_r;   assign b2.prod_data = pd_r;
    assign b0.out_ready = or_r;   assign b1.out_ready = or_r;   assign b2.out_ready = or_r;

    neuron_accumulator #(.N_INPUTS(4), .ACC_W(48), .RELU_EN(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0));
    neuron_accumulator #(.N_INPUTS(4), .ACC_W(48), .RELU_EN(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1));
    neuron_accumulator #(.N_INPUTS(784), .ACC_W(48), .RELU_EN(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2));

    logic        obs_valid, obs_prod_ready, obs_busy, obs_sat;
    logic [31:0] obs_data;

    always_comb begin
        obs_valid = b0.out_valid; obs_prod_ready = b0.prod_ready; obs_busy = b0.busy;
        obs_sat = b0.sat_flag; obs_data = b0.out_data;
        case (sel)
            1: begin
                obs_valid = b1.out_valid; obs_prod_ready = b1.prod_ready; obs_busy = b1.busy;
                obs_sat = b1.sat_flag; obs_data = b1.out_data;
            end
            2: begin
                obs_valid = b2.out_valid; obs_prod_ready = b2.prod_ready; obs_busy = b2.busy;
                obs_sat = b2.sat_flag; obs_data = b2.out_data;
            end
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int b, input int n, input bit relu);
        longint s, maxv, minv;
        int     r;
        exp_t   e;
        maxv = 64'sd2147483647;
        minv = -maxv - 1;
        s = longint'(b);
        for (int i = 0; i < n; i++) s += longint'(prod_tab[i]);
        e.sat = (s > maxv) || (s < minv);
        if (s > maxv)      r = 32'h7FFF_FFFF;
        else if (s < minv) r = 32'h8000_0000;
        else               r = int'(s);
        if (relu && r < 0) r = 0;
        e.data = r;
        return e;
    endfunction

    // Scoreboard consumer and stall-stability checker.
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_sat = 1'b0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && obs_valid) begin
            if (prev_valid && !prev_ready) begin
                check_eq("stall_data", obs_data, prev_data);
                check_eq("stall_sat", obs_sat, prev_sat);
            end
            if (or_r) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out", obs_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_data", obs_data, e.data);
                    check_eq("sat_flag", obs_sat, e.sat);
                end
            end
        end
        prev_valid <= obs_valid && rst_n;
        prev_ready <= or_r;
        prev_data  <= obs_data;
        prev_sat   <= obs_sat;
    end

    // Launch one neuron on instance s; products come from prod_tab[0..n-1].
    task automatic run_neuron(input int s, input int b, input int n, input bit bub,
                              input int stall);
        int i;
        int guard;
        exp_q.push_back(model(b, n, (s != 1)));
        sel  = s;
        or_r = (stall == 0);
        @(posedge clk); #1;
        start_r = 1'b1;
        bias_r  = b;
        @(posedge clk); #1;
        start_r = 1'b0;
        i = 0;
        guard = 0;
        while (i < n && guard < 4 * n + 20) begin
            if (bub && $urandom_range(0, 2) == 0) begin
                pv_r    = 1'b0;
                start_r = 1'($urandom_range(0, 1));
            end else begin
                pv_r    = 1'b1;
                pd_r    = prod_tab[i];
                start_r = 1'b0;
            end
            @(negedge clk);
            if (bub) check_eq("accum_ready", obs_prod_ready, 1'b1);
            @(posedge clk);
            if (pv_r) i++;
            #1;
            guard++;
        end
        pv_r    = 1'b0;
        start_r = 1'b0;
        // Now just past the edge that accepted the final product.
        @(negedge clk);
        check_eq("bias_cycle_valid", obs_valid, 1'b0);
        check_eq("bias_cycle_ready", obs_prod_ready, 1'b0);
        @(negedge clk);
        check_eq("latency_valid", obs_valid, 1'b1);
        check_eq("out_cycle_ready", obs_prod_ready, 1'b0);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            start_r = 1'b1;
        end
        or_r = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (!obs_valid) break;
        end
        check_eq("handshake_done", obs_valid, 1'b0);
        start_r = 1'b0;
        check_eq("start_ignored_idle", obs_busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, obs_busy, 1'b0);
        check_eq({tag, "_prod_ready"}, obs_prod_ready, 1'b0);
        check_eq({tag, "_out_valid"}, obs_valid, 1'b0);
        check_eq({tag, "_out_data"}, obs_data, 32'h0);
        check_eq({tag, "_sat"}, obs_sat, 1'b0);
    endtask

    task automatic set4(input int a, input int b, input int c, input int d);
        prod_tab[0] = a; prod_tab[1] = b; prod_tab[2] = c; prod_tab[3] = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0; start_r = 1'b0; bias_r = '0; pv_r = 1'b0; pd_r = '0; or_r = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic sums, ReLU and pass-through
        set4(1, 2, 3, 4);
        run_neuron(0, 10, 4, 1'b0, 0);
        set4(-5, -6, -7, -8);
        run_neuron(0, 0, 4, 1'b0, 0);
        run_neuron(1, 0, 4, 1'b0, 0);

        // Saturation at both ends
        set4(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_neuron(0, 1, 4, 1'b0, 0);
        set4(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        run_neuron(1, 0, 4, 1'b0, 0);

        // Random bubbles, output stalls and stray start pulses
        for (int t = 0; t < 6; t++) begin
            for (int j = 0; j < 4; j++) begin
                prod_tab[j] = (t < 3) ? int'($urandom_range(0, 2000)) - 1000 : int'($urandom());
            end
            run_neuron(t % 2, int'($urandom_range(0, 200)) - 100, 4, 1'b1, 5);
        end

        // Asynchronous reset mid-neuron, then a clean neuron
        set4(1, 2, 3, 4);
        run_neuron(0, 10, 4, 1'b0, 0);
        @(posedge clk); #1;
        start_r = 1'b1; bias_r = 5;
        @(posedge clk); #1;
        start_r = 1'b0; pv_r = 1'b1; pd_r = 7;
        @(posedge clk); #1;
        pd_r = 9;
        @(posedge clk); #2;
        pv_r  = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        set4(1, 1, 1, 1);
        run_neuron(0, 0, 4, 1'b0, 0);

        // Full-size neuron, then a second one straight after
        for (int j = 0; j < 784; j++) prod_tab[j] = 1;
        run_neuron(2, -784, 784, 1'b0, 0);
        for (int j = 0; j < 784; j++) prod_tab[j] = int'($urandom_range(0, 2000)) - 1000;
        run_neuron(2, int'($urandom_range(0, 2000)) - 500, 784, 1'b1, 2);

        repeat (3) @(negedge clk);
        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
